// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI flash arbiter.
//   - arb_state_t / ST_*   : arbiter state encoding
//   - CSEL_IDLE, CLK_IDLE,
//     MOSI_IDLE            : flash pin levels while no master owns the bus
//   - DEFAULT_CS_GAP       : default chip-select deselect time in clk_48mhz cycles
//   - GAP_W                : width of the deselect-gap counter (CS_GAP <= 2**GAP_W)
package spi_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GRANT = 2'd1;
    localparam arb_state_t ST_GUARD = 2'd2;

    localparam logic CSEL_IDLE = 1'b1;
    localparam logic CLK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    // 8 cycles at 48 MHz is about 167 ns of flash tSHSL
    localparam int unsigned DEFAULT_CS_GAP = 8;
    localparam int unsigned GAP_W          = 8;

endpackage

// File: rtl/spi_flash_arbiter.sv
// Two-master arbiter for a single SPI flash pin set.
// Master 0 is the DFU flash engine, master 1 a secondary reader. Grants are
// round-robin, held for a whole transaction, and followed by a CS_GAP-cycle
// deselect guard before the next grant.
//
// Ports:
//   clk_48mhz    in   sole clock
//   reset        in   synchronous, active-high
//   req[1:0]     in   per-master request level, held for the whole transaction
//   gnt[1:0]     out  registered grant, one-hot or zero
//   m_csel[1:0]  in   per-master chip-select (active low)
//   m_clk[1:0]   in   per-master SPI clock
//   m_mosi[1:0]  in   per-master MOSI
//   m_miso[1:0]  out  per-master MISO (0 for the non-owner)
//   spi_csel     out  flash chip-select (active low)
//   spi_clk      out  flash clock
//   spi_mosi     out  flash MOSI
//   spi_miso     in   flash MISO
//   busy         out  high while granted or in the deselect guard
//   timeout_err  out  sticky grant-timeout flag (only with SPI_ARB_TIMEOUT_EN)
//
// Build option: define SPI_ARB_TIMEOUT_EN to revoke grants held for
// TIMEOUT_CYCLES cycles.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
`ifdef SPI_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
`endif
    parameter int unsigned CS_GAP = DEFAULT_CS_GAP
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] m_csel,
    input  logic [1:0] m_clk,
    input  logic [1:0] m_mosi,
    output logic [1:0] m_miso,
    output logic       spi_csel,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       busy,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic       timeout_err,
`endif
    input  logic       spi_miso
);

    // Contended requests go to the master that did not own the bus last.
    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        return (r == 2'b11) ? ~last : r[1];
    endfunction

    arb_state_t       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_owner_q, last_owner_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             owner;
    logic             pick;
    logic             release_bus;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 21;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign timeout_err = timeout_err_q;
`endif

    // last_owner doubles as the current owner while in ST_GRANT
    assign owner = last_owner_q;
    assign pick  = rr_pick(req, last_owner_q);
    assign gnt   = gnt_q;
    assign busy  = (state_q == ST_GRANT) || (state_q == ST_GUARD);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'b00;
            last_owner_q <= 1'b1;
            gap_q        <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            grant_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            gap_q        <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
            grant_cnt_q   <= grant_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        gap_d        = gap_q;
        release_bus  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        grant_cnt_d   = grant_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    last_owner_d = pick;
                    gnt_d        = pick ? 2'b10 : 2'b01;
                    state_d      = ST_GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
                    grant_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Dropping req alone is not enough: wait for the owner to end its frame.
                release_bus = !req[owner] && m_csel[owner];
`ifdef SPI_ARB_TIMEOUT_EN
                grant_cnt_d = grant_cnt_q + 1'b1;
                if (grant_cnt_q == TIMEOUT_LAST) begin
                    release_bus   = 1'b1;
                    timeout_err_d = 1'b1;
                end
`endif
                if (release_bus) begin
                    state_d = ST_GUARD;
                    gnt_d   = 2'b00;
                    gap_d   = GAP_W'(CS_GAP - 1);
                end
            end
            ST_GUARD: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Pin mux: combinational pass-through from the owner, idle levels otherwise.
    always_comb begin
        spi_csel = CSEL_IDLE;
        spi_clk  = CLK_IDLE;
        spi_mosi = MOSI_IDLE;
        m_miso   = 2'b00;
        if (state_q == ST_GRANT) begin
            spi_csel      = m_csel[owner];
            spi_clk       = m_clk[owner];
            spi_mosi      = m_mosi[owner];
            m_miso[owner] = spi_miso;
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

    localparam int unsigned CS_GAP = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 64;
    logic timeout_err;
`endif

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [1:0] req       = 2'b00;
    logic [1:0] m_csel    = 2'b11;
    logic [1:0] m_clk     = 2'b00;
    logic [1:0] m_mosi    = 2'b00;
    logic       spi_miso  = 1'b0;
    logic [1:0] gnt;
    logic [1:0] m_miso;
    logic       spi_csel, spi_clk, spi_mosi, busy;

    always #5 clk_48mhz = ~clk_48mhz;

    spi_flash_arbiter #(
`ifdef SPI_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(TIMEOUT),
`endif
        .CS_GAP(CS_GAP)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .m_csel    (m_csel),
        .m_clk     (m_clk),
        .m_mosi    (m_mosi),
        .m_miso    (m_miso),
        .spi_csel  (spi_csel),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .busy      (busy),
`ifdef SPI_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .spi_miso  (spi_miso)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: who owns the bus, when the guard ends,
    // and the earliest edge at which a new grant may be issued.
    int cyc         = 0;
    int m_owner     = -1;
    int m_last      = 1;
    int m_guard_end = -1;
    int m_free_at   = 0;
    int m_gstart    = 0;
    bit m_terr      = 1'b0;
    bit m_to_evt    = 1'b0;

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] csel;
        logic [1:0] sclk;
        logic [1:0] mosi;
        logic       miso;
        logic [1:0] e_gnt;
        logic       e_busy;
        logic       e_csel;
        logic       e_clk;
        logic       e_mosi;
        logic [1:0] e_miso;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] tx, fl, rx, mo;
    logic       m1_leak;
    int         gap_cycles, hold, w, o;
    bit         got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        int e;
        bit rel;
        e        = cyc;
        m_to_evt = 1'b0;
        if (reset) begin
            m_owner     = -1;
            m_last      = 1;
            m_guard_end = -1;
            m_free_at   = e + 1;
            m_terr      = 1'b0;
        end else if (m_owner >= 0) begin
            rel = !req[m_owner] && m_csel[m_owner];
`ifdef SPI_ARB_TIMEOUT_EN
            if (e - m_gstart == int'(TIMEOUT)) begin
                rel      = 1'b1;
                m_terr   = 1'b1;
                m_to_evt = 1'b1;
            end
`endif
            if (rel) begin
                m_owner     = -1;
                m_guard_end = e + int'(CS_GAP);
                m_free_at   = e + int'(CS_GAP) + 1;
            end
        end else if (e >= m_free_at && req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else m_owner = req[1] ? 1 : 0;
            m_last   = m_owner;
            m_gstart = e;
        end
        cyc++;
    endtask

    task automatic check_model();
        logic [1:0] eg, emiso;
        logic       ec, ek, eo, eb;
        eg = 2'b00; emiso = 2'b00; ec = 1'b1; ek = 1'b0; eo = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner]    = 1'b1;
            ec             = m_csel[m_owner];
            ek             = m_clk[m_owner];
            eo             = m_mosi[m_owner];
            emiso[m_owner] = spi_miso;
        end
        eb = (m_owner >= 0) || ((cyc - 1) < m_guard_end);
        chk("model_gnt_busy", 32'({busy, gnt}), 32'({eb, eg}));
        chk("model_pins", 32'({spi_csel, spi_clk, spi_mosi, m_miso}), 32'({ec, ek, eo, emiso}));
`ifdef SPI_ARB_TIMEOUT_EN
        chk("model_timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
    endtask

    // One clock: update the reference at the edge, then compare 1 time unit later.
    task automatic step();
        logic [1:0] pg;
        logic       pc, pr;
        #1;
        pg = gnt; pc = spi_csel; pr = reset;
        @(posedge clk_48mhz);
        model_update();
        #1;
        check_model();
        if (!pr && !m_to_evt) begin
            chk("gnt_not_both", 32'(gnt != 2'b11), 32'd1);
            if (pg != gnt) chk("gnt_change_with_csel_high", 32'(pc), 32'd1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; m_csel = 2'b11; m_clk = 2'b00; m_mosi = 2'b00;
        spi_miso = 1'b0;
        step();
        chk("reset_state", 32'({gnt, busy, spi_csel, spi_clk, spi_mosi}), 32'(6'b00_0_1_0_0));
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] cs, input logic [1:0] ck,
                                input logic [1:0] mo_in, input logic mi, input logic [1:0] eg,
                                input logic eb, input logic ec, input logic ek, input logic eo,
                                input logic [1:0] em);
        vec_t v;
        v = '{req: r, csel: cs, sclk: ck, mosi: mo_in, miso: mi, e_gnt: eg, e_busy: eb,
              e_csel: ec, e_clk: ek, e_mosi: eo, e_miso: em};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // After reset master 1 counts as last owner.
        vecs.push_back(mk(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b01, 2'b10, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00));
        vecs.push_back(mk(2'b01, 2'b00, 2'b10, 2'b10, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01));
        vecs.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < int'(CS_GAP) - 1; i++)
            vecs.push_back(mk(2'b10, 2'b01, 2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
                              2'b00));
        vecs.push_back(mk(2'b10, 2'b01, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10));

        do_reset();
        foreach (vecs[i]) begin
            req = vecs[i].req; m_csel = vecs[i].csel; m_clk = vecs[i].sclk;
            m_mosi = vecs[i].mosi; spi_miso = vecs[i].miso;
            step();
            chk($sformatf("vec%0d", i),
                32'({gnt, busy, spi_csel, spi_clk, spi_mosi, m_miso}),
                32'({vecs[i].e_gnt, vecs[i].e_busy, vecs[i].e_csel, vecs[i].e_clk,
                     vecs[i].e_mosi, vecs[i].e_miso}));
        end

        // Master 0 reads JEDEC ID: 0x9F out, 0xEF back from the flash.
        do_reset();
        req = 2'b01;
        step();
        chk("a_grant", 32'(gnt), 32'(2'b01));
        m_csel = 2'b10;
        step();
        chk("a_csel_low", 32'(spi_csel), 32'd0);
        tx = 8'h9F; fl = 8'hEF; rx = 8'h00; mo = 8'h00; m1_leak = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            m_clk[0] = 1'b0; m_mosi[0] = tx[i]; spi_miso = fl[i];
            step();
            m_clk[0] = 1'b1;
            step();
            mo = {mo[6:0], spi_mosi};
            rx = {rx[6:0], m_miso[0]};
            m1_leak = m1_leak | m_miso[1];
        end
        chk("a_mosi_byte", 32'(mo), 32'h9F);
        chk("a_miso_byte", 32'(rx), 32'hEF);
        chk("a_miso1_quiet", 32'(m1_leak), 32'd0);

        // Master 0 drops req mid-frame; master 1 waits.
        m_clk = 2'b00; req = 2'b10; m_csel = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("b_hold%0d", i), 32'(gnt), 32'(2'b01));
        end
        m_csel = 2'b11;
        step();
        chk("b_release", 32'(gnt), 32'(2'b00));
        gap_cycles = 0; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (gnt != 2'b00) got = 1'b1;
            else begin
                if (busy) gap_cycles++;
                step();
            end
        end
        chk("b_regrant_seen", 32'(got), 32'd1);
        chk("b_guard_cycles", 32'(gap_cycles), 32'(CS_GAP));
        chk("b_next_owner", 32'(gnt), 32'(2'b10));
        req = 2'b00;
        step();

        // Continuous contention: strict alternation.
        do_reset();
        req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            w = 0;
            while (gnt == 2'b00 && w < 30) begin
                step();
                w++;
            end
            chk("c_grant_seen", 32'(gnt != 2'b00), 32'd1);
            o = gnt[1] ? 1 : 0;
            chk($sformatf("c_order%0d", t), 32'(o), 32'(t % 2));
            m_csel[o] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_clk[o] = ~m_clk[o];
                step();
            end
            m_clk[o] = 1'b0; m_csel[o] = 1'b1;
            step();
            req[o] = 1'b0;
            step();
            req[o] = 1'b1;
        end
        req = 2'b00;
        step();

        // Reset in the middle of a master-1 transfer.
        do_reset();
        req = 2'b10;
        step();
        chk("d_grant1", 32'(gnt), 32'(2'b10));
        m_csel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            m_clk[1] = ~m_clk[1]; m_mosi[1] = 1'($urandom);
            step();
        end
        reset = 1'b1;
        step();
        chk("d_after_reset", 32'({gnt, spi_csel, busy}), 32'(4'b00_1_0));
        reset = 1'b0; req = 2'b11; m_csel = 2'b11; m_clk = 2'b00;
        step();
        chk("d_first_after_reset", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        step();

`ifdef SPI_ARB_TIMEOUT_EN
        do_reset();
        req = 2'b01; m_csel = 2'b10;
        step();
        hold = 0; w = 0;
        while (gnt == 2'b01 && w < 200) begin
            hold++;
            step();
            w++;
        end
        chk("e_hold_cycles", 32'(hold), 32'(TIMEOUT));
        chk("e_revoked", 32'({gnt, spi_csel, timeout_err}), 32'(4'b00_1_1));
        req = 2'b11;
        w = 0;
        while (gnt == 2'b00 && w < 40) begin
            step();
            w++;
        end
        chk("e_master1_next", 32'(gnt), 32'(2'b10));
        req = 2'b00; m_csel = 2'b11;
        for (int i = 0; i < 12; i++) step();
        chk("e_err_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        chk("e_err_cleared", 32'(timeout_err), 32'd0);
`endif

        // Randomised traffic against the reference.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
            if ($urandom_range(0, 3) == 0) m_csel[0] = ~m_csel[0];
            if ($urandom_range(0, 3) == 0) m_csel[1] = ~m_csel[1];
            m_clk    = 2'($urandom);
            m_mosi   = 2'($urandom);
            spi_miso = 1'($urandom);
            reset    = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
